// File: rtl/kt_pkg.sv
// Shared constants and types for the 5x5 knight's-tour checker.
// Contents: board/tour sizes, verdict error codes, coordinate/step types,
// and a helper that maps an on-board square to its visited-mask bit.
package kt_pkg;

  localparam int BOARD_N  = 5;
  localparam int TOUR_LEN = BOARD_N * BOARD_N;

  typedef logic [2:0] coord_t;
  typedef logic [4:0] step_t;
  typedef logic [2:0] err_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } sq_t;

  // Error codes; a lower code wins when several fire on the same beat.
  localparam err_t ERR_NONE    = 3'd0;
  localparam err_t ERR_RANGE   = 3'd1;
  localparam err_t ERR_SEQ     = 3'd2;
  localparam err_t ERR_PREFIX  = 3'd3;
  localparam err_t ERR_KNIGHT  = 3'd4;
  localparam err_t ERR_REVISIT = 3'd5;
  localparam err_t ERR_TIMEOUT = 3'd6;
  localparam err_t ERR_CAPTURE = 3'd7;

  // 5*y + x for on-board squares (0..24); only meaningful when x,y <= 4.
  function automatic step_t sq_idx(input coord_t x, input coord_t y);
    return {y, 2'b00} + {2'b00, y} + {2'b00, x};
  endfunction

endpackage

// File: rtl/kt_knight_adj.sv
// Knight-move detector: true when (x1,y1) is one knight hop from (x0,y0).
// Ports: x0_i/y0_i previous square, x1_i/y1_i current square, is_knight_o.
// Purely combinational; inputs may be off-board (up to 7).
module kt_knight_adj
  import kt_pkg::*;
(
  input  coord_t x0_i,
  input  coord_t y0_i,
  input  coord_t x1_i,
  input  coord_t y1_i,
  output logic   is_knight_o
);

  logic signed [3:0] sdx, sdy;
  logic        [3:0] adx, ady;

  // Zero-extended 4-bit signed difference, then magnitude.
  assign sdx = $signed({1'b0, x1_i}) - $signed({1'b0, x0_i});
  assign sdy = $signed({1'b0, y1_i}) - $signed({1'b0, y0_i});
  assign adx = sdx[3] ? -sdx : sdx;
  assign ady = sdy[3] ? -sdy : sdy;

  assign is_knight_o = ((adx == 4'd1) && (ady == 4'd2)) ||
                       ((adx == 4'd2) && (ady == 4'd1));

endmodule

// File: rtl/kt_tour_checker.sv
// Knight's-tour checker: snoops the solver prefix, checks the 25-beat result
// stream for range/sequence/prefix/knight/revisit errors, reports one verdict.
// Ports: in_* prefix snoop, out_* result stream, chk_* verdict (held until next chk_done).
module kt_tour_checker
  import kt_pkg::*;
#(
  parameter int TIMEOUT = 65535,
  parameter int TMO_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [2:0] in_x,
  input  logic [2:0] in_y,
  input  logic [4:0] move_num,
  input  logic       out_valid,
  input  logic [2:0] out_x,
  input  logic [2:0] out_y,
  input  logic [4:0] move_out,
  output logic       chk_done,
  output logic       chk_pass,
  output logic [2:0] chk_err,
  output logic [4:0] chk_step
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CAPTURE = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_CHECK   = 3'd3;
  localparam logic [2:0] ST_REPORT  = 3'd4;

  localparam step_t            LAST_STEP = step_t'(TOUR_LEN);
  localparam logic [TMO_W-1:0] WAIT_LAST = TMO_W'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  step_t            plen_q, plen_d;
  step_t            cnt_q, cnt_d;
  step_t            beats_q, beats_d;
  logic [TMO_W-1:0] wait_q, wait_d;
  logic [24:0]      visited_q, visited_d;
  sq_t              prev_q, prev_d;
  err_t             err_q, err_d;
  step_t            step_q, step_d;
  logic             pass_q, pass_d;
  err_t             err_out_q, err_out_d;
  step_t            step_out_q, step_out_d;
  sq_t              prefix_q [TOUR_LEN];

  logic  pf_we;
  step_t pf_idx;
  sq_t   in_sq, out_sq, pf_rd;
  step_t k, sq;
  logic  in_rng, is_knight, beat_acc, go_report;
  err_t  beat_err;

  assign in_sq  = '{x: in_x,  y: in_y};
  assign out_sq = '{x: out_x, y: out_y};

  // Step number of the beat presented this cycle; beats_q is 0 on entering WAIT.
  assign k      = beats_q + 5'd1;
  assign in_rng = (out_x <= 3'd4) && (out_y <= 3'd4);
  assign sq     = sq_idx(out_x, out_y);
  // beats_q is k-1; clamp so the read stays inside the file after beat 25.
  assign pf_rd  = prefix_q[(beats_q < LAST_STEP) ? beats_q : 5'd0];

  kt_knight_adj u_adj (
    .x0_i        (prev_q.x),
    .y0_i        (prev_q.y),
    .x1_i        (out_x),
    .y1_i        (out_y),
    .is_knight_o (is_knight)
  );

  always_comb begin
    beat_err = ERR_NONE;
    if (!in_rng)                                   beat_err = ERR_RANGE;
    else if (move_out != k)                        beat_err = ERR_SEQ;
    else if ((k <= plen_q) && (out_sq != pf_rd))   beat_err = ERR_PREFIX;
    else if ((k > 5'd1) && !is_knight)             beat_err = ERR_KNIGHT;
    else if (visited_q[sq])                        beat_err = ERR_REVISIT;
  end

  assign beat_acc = out_valid && ((state_q == ST_WAIT) || (state_q == ST_CHECK));

  always_comb begin
    state_d    = state_q;
    plen_d     = plen_q;
    cnt_d      = cnt_q;
    beats_d    = beats_q;
    wait_d     = wait_q;
    visited_d  = visited_q;
    prev_d     = prev_q;
    err_d      = err_q;
    step_d     = step_q;
    pass_d     = pass_q;
    err_out_d  = err_out_q;
    step_out_d = step_out_q;
    pf_we      = 1'b0;
    pf_idx     = 5'd0;
    go_report  = 1'b0;

    // Every accepted beat is scored; only the first error is latched.
    if (beat_acc) begin
      beats_d = k;
      prev_d  = out_sq;
      if (in_rng) visited_d[sq] = 1'b1;
      if ((err_q == ERR_NONE) && (beat_err != ERR_NONE)) begin
        err_d  = beat_err;
        step_d = k;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          plen_d  = move_num;
          cnt_d   = 5'd1;
          pf_we   = 1'b1;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (in_valid) begin
          // Excess beats are counted (saturating) but not stored.
          if (cnt_q < LAST_STEP) begin
            pf_we  = 1'b1;
            pf_idx = cnt_q;
          end
          if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
        end else begin
          if ((cnt_q != plen_q) || (plen_q == 5'd0) || (plen_q > LAST_STEP)) begin
            err_d  = ERR_CAPTURE;
            step_d = 5'd0;
          end
          wait_d  = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (out_valid) begin
          state_d = ST_CHECK;
        end else if (wait_q == WAIT_LAST) begin
          if (err_q == ERR_NONE) begin
            err_d  = ERR_TIMEOUT;
            step_d = 5'd0;
          end
          go_report = 1'b1;
        end else begin
          wait_d = wait_q + TMO_W'(1);
        end
      end
      ST_CHECK: begin
        if (out_valid) begin
          if (k == LAST_STEP) go_report = 1'b1;
        end else begin
          // Stream ended short: the missing beat is the error step.
          if (err_q == ERR_NONE) begin
            err_d  = ERR_SEQ;
            step_d = k;
          end
          go_report = 1'b1;
        end
      end
      ST_REPORT: begin
        visited_d = '0;
        cnt_d     = 5'd0;
        beats_d   = 5'd0;
        wait_d    = '0;
        err_d     = ERR_NONE;
        step_d    = 5'd0;
        plen_d    = 5'd0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Verdict registers load on the edge entering REPORT so they are valid
    // in the same cycle chk_done is high.
    if (go_report) begin
      state_d    = ST_REPORT;
      pass_d     = (err_d == ERR_NONE);
      err_out_d  = err_d;
      step_out_d = step_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      plen_q     <= 5'd0;
      cnt_q      <= 5'd0;
      beats_q    <= 5'd0;
      wait_q     <= '0;
      visited_q  <= '0;
      prev_q     <= '0;
      err_q      <= ERR_NONE;
      step_q     <= 5'd0;
      pass_q     <= 1'b0;
      err_out_q  <= ERR_NONE;
      step_out_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      plen_q     <= plen_d;
      cnt_q      <= cnt_d;
      beats_q    <= beats_d;
      wait_q     <= wait_d;
      visited_q  <= visited_d;
      prev_q     <= prev_d;
      err_q      <= err_d;
      step_q     <= step_d;
      pass_q     <= pass_d;
      err_out_q  <= err_out_d;
      step_out_q <= step_out_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TOUR_LEN; i++) prefix_q[i] <= '0;
    end else if (pf_we) begin
      prefix_q[pf_idx] <= in_sq;
    end
  end

  assign chk_done = (state_q == ST_REPORT);
  assign chk_pass = pass_q;
  assign chk_err  = err_out_q;
  assign chk_step = step_out_q;

endmodule

// File: tb/tb_kt_tour_checker.sv
module tb_kt_tour_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_x, in_y;
  logic [4:0] move_num;
  logic       out_valid;
  logic [2:0] out_x, out_y;
  logic [4:0] move_out;
  logic       chk_done, chk_pass;
  logic [2:0] chk_err;
  logic [4:0] chk_step;

  always #5 clk = ~clk;

  kt_tour_checker #(.TIMEOUT(100), .TMO_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_x      (in_x),
    .in_y      (in_y),
    .move_num  (move_num),
    .out_valid (out_valid),
    .out_x     (out_x),
    .out_y     (out_y),
    .move_out  (move_out),
    .chk_done  (chk_done),
    .chk_pass  (chk_pass),
    .chk_err   (chk_err),
    .chk_step  (chk_step)
  );

  int n_pass = 0;
  int n_chk  = 0;

  // A legal 5x5 tour from the corner (0,0).
  int tx[25] = '{0,2,4,3,4,2,0,1,2,4,3,1,0,1,3,4,2,0,1,3,4,3,1,0,2};
  int ty[25] = '{0,1,0,2,4,3,4,2,0,1,3,4,2,0,1,3,4,3,1,0,2,4,3,1,2};
  int bx[25], by[25], px[25], py[25];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic load_tour();
    for (int i = 0; i < 25; i++) begin
      bx[i] = tx[i];
      by[i] = ty[i];
    end
  endtask

  // Drive n prefix beats, then one idle cycle so CAPTURE closes into WAIT.
  task automatic send_prefix(input int n, input int plen);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_x     = 3'(px[i]);
      in_y     = 3'(py[i]);
      move_num = (i == 0) ? 5'(plen) : 5'd0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic stream(input int n);
    for (int k = 1; k <= n; k++) begin
      out_valid = 1'b1;
      out_x     = 3'(bx[k-1]);
      out_y     = 3'(by[k-1]);
      move_out  = 5'(k);
      @(posedge clk); #1;
    end
    out_valid = 1'b0;
  endtask

  // Called one cycle after the finishing edge: chk_done must be high now, low next cycle.
  task automatic verdict(input string tag, input int p, input int e, input int s);
    chk({tag, ".done"}, 32'(chk_done), 32'd1);
    chk({tag, ".pass"}, 32'(chk_pass), 32'(p));
    chk({tag, ".err"},  32'(chk_err),  32'(e));
    chk({tag, ".step"}, 32'(chk_step), 32'(s));
    @(posedge clk); #1;
    chk({tag, ".done_1cyc"}, 32'(chk_done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; move_num = '0;
    out_valid = 1'b0; out_x = '0; out_y = '0; move_out = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.done", 32'(chk_done), 32'd0);
    chk("rst.pass", 32'(chk_pass), 32'd0);
    chk("rst.err",  32'(chk_err),  32'd0);
    chk("rst.step", 32'(chk_step), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Legal tour, single-square prefix.
    px[0] = 0; py[0] = 0;
    load_tour();
    send_prefix(1, 1);
    stream(24);
    chk("legal.nodone_early", 32'(chk_done), 32'd0);
    stream_last();
    verdict("legal", 1, 0, 0);

    // Illegal move at beat 2.
    load_tour();
    bx[1] = 1; by[1] = 1;
    send_prefix(1, 1);
    stream(25);
    verdict("knight", 0, 4, 2);

    // Beat 7 revisits beat 3's square via a legal knight hop.
    load_tour();
    bx[0] = 0; by[0] = 0;
    bx[1] = 2; by[1] = 1;
    bx[2] = 4; by[2] = 2;
    bx[3] = 3; by[3] = 4;
    bx[4] = 2; by[4] = 2;
    bx[5] = 3; by[5] = 0;
    bx[6] = 4; by[6] = 2;
    send_prefix(1, 1);
    stream(25);
    verdict("revisit", 0, 5, 7);

    // Prefix mismatch on a legal knight move.
    load_tour();
    px[0] = 0; py[0] = 0; px[1] = 1; py[1] = 2;
    send_prefix(2, 2);
    stream(25);
    verdict("prefix", 0, 3, 2);

    // Early drop after 10 beats.
    load_tour();
    px[0] = 0; py[0] = 0;
    send_prefix(1, 1);
    stream(10);
    chk("drop.nodone_lowcyc", 32'(chk_done), 32'd0);
    @(posedge clk); #1;
    verdict("drop", 0, 2, 11);

    // Prefix length disagrees with beats supplied.
    load_tour();
    send_prefix(1, 2);
    stream(25);
    verdict("capture", 0, 7, 0);

    // Timeout: no result stream at all.
    send_prefix(1, 1);
    repeat (99) @(posedge clk);
    #1;
    chk("tmo.nodone_c100", 32'(chk_done), 32'd0);
    @(posedge clk); #1;
    chk("tmo.done", 32'(chk_done), 32'd1);
    chk("tmo.pass", 32'(chk_pass), 32'd0);
    chk("tmo.err",  32'(chk_err),  32'd6);
    @(posedge clk); #1;

    // Reset mid-CHECK, then a clean solve.
    load_tour();
    send_prefix(1, 1);
    stream(5);
    rst_n = 1'b0;
    #1;
    chk("midrst.done", 32'(chk_done), 32'd0);
    chk("midrst.err",  32'(chk_err),  32'd0);
    chk("midrst.step", 32'(chk_step), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst.nodone", 32'(chk_done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_prefix(1, 1);
    stream(25);
    verdict("after_rst", 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Final beat of the legal run, sent separately to probe chk_done before it.
  task automatic stream_last();
    out_valid = 1'b1;
    out_x     = 3'(bx[24]);
    out_y     = 3'(by[24]);
    move_out  = 5'd25;
    @(posedge clk); #1;
    out_valid = 1'b0;
  endtask

endmodule
